reg_rd_ser: RTL and testbench
=============================

REG_RD_SER -- requirements
Module: reg_rd_ser

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, width of each register in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 1, register select width; NREG = 2**ADDR_W registers.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port regs  input  NREG*DATA_W  flattened register contents; register k occupies bits [k*DATA_W +: DATA_W].
REQ-006 The block SHALL have port rd_req  input  1  read request, sampled on clk.
REQ-007 The block SHALL have port rd_addr  input  ADDR_W  register select, sampled with rd_req.
REQ-008 The block SHALL have port busy  output  1  transfer in progress.
REQ-009 The block SHALL have port sdo  output  1  serial data out.
REQ-010 The block SHALL have port sdo_valid  output  1  sdo carries a valid bit this cycle.
REQ-011 The block SHALL have port done  output  1  one-cycle end-of-transfer pulse.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-013 In IDLE with rd_req=1 at edge N, the block SHALL snapshot regs[rd_addr] into a DATA_W shift register, load bit counter, and enter SHIFT.
REQ-014 Changes on regs or rd_addr after edge N SHALL NOT affect the transfer in progress.
REQ-015 In SHIFT, the block SHALL present the snapshot MSB-first, one bit per cycle, on cycles N+1..N+DATA_W, with sdo_valid=1 on exactly those cycles.
REQ-016 After the last bit, the block SHALL enter DONE for one cycle (N+DATA_W+1 without parity): done=1, sdo_valid=0, sdo=0; then return to IDLE.
REQ-017 busy SHALL be 1 from cycle N+1 through the DONE cycle inclusive, 0 otherwise.
REQ-018 rd_req asserted while busy=1 (SHIFT or DONE) SHALL be ignored, not queued.
REQ-019 rd_req held high continuously SHALL start a new transfer at the first IDLE edge after DONE; back-to-back spacing = DATA_W+2 cycles (no parity).
REQ-020 sdo SHALL be 0 whenever sdo_valid=0.
REQ-021 Bit counter SHALL be sized ceil(log2(DATA_W+2)) and SHALL NOT wrap within a transfer.

Reset
REQ-022 rst=1 SHALL asynchronously force state=IDLE, busy=0, sdo=0, sdo_valid=0, done=0, shift register and counter to 0.
REQ-023 rst asserted mid-transfer SHALL abort it with no done pulse; after rst release the block SHALL accept a new rd_req on the first clk edge.

Configuration
REQ-024 With macro REG_RD_PARITY_EN defined, the block SHALL append one even-parity bit (XOR of the DATA_W snapshot bits) on cycle N+DATA_W+1 with sdo_valid=1, moving DONE to cycle N+DATA_W+2 and spacing to DATA_W+3.
REQ-025 Without REG_RD_PARITY_EN, the block SHALL emit exactly DATA_W bits and contain no parity logic.

Verification
REQ-026 regs={8'h3C,8'hA5}, rd_req=1, rd_addr=0 at edge N -> sdo 1,0,1,0,0,1,0,1 on N+1..N+8, sdo_valid=1 on those cycles, done=1 at N+9.
REQ-027 rd_addr=1, regs[15:8]=8'h3C, regs changed to 8'hFF at N+2 -> serial stream 0,0,1,1,1,1,0,0 unchanged.
REQ-028 rd_req pulsed at N+3 during transfer -> ignored; busy falls after N+9 DONE, no second transfer.
REQ-029 rst asserted at N+4 -> busy, sdo, sdo_valid, done all 0 immediately (before next edge), no done pulse; new request after release completes normally.
REQ-030 REG_RD_PARITY_EN defined, data 8'hA5 -> 8 data bits then parity 0 at N+9, done at N+10; data 8'h01 -> parity 1.

Source files
------------

// File: rtl/reg_rd_ser.sv
// Register read serializer: snapshots one of NREG registers and shifts it out MSB-first.
// Define REG_RD_PARITY_EN to append an even-parity bit after the data bits.
module reg_rd_ser #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    regs,
  input  logic                             rd_req,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic                             busy,
  output logic                             sdo,
  output logic                             sdo_valid,
  output logic                             done
);

  localparam int NREG = 2**ADDR_W;
`ifdef REG_RD_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W + 2);
  // Counter holds the number of bits still to be presented after the current one.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [DATA_W-1:0] snap;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              busy_next, sdo_next, sdo_valid_next, done_next;
  logic [DATA_W-1:0] reg_arr [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_unpack
      assign reg_arr[gi] = regs[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign snap = reg_arr[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      cnt       <= cnt_next;
      busy      <= busy_next;
      sdo       <= sdo_next;
      sdo_valid <= sdo_valid_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_req) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shreg_next     = shreg;
    cnt_next       = cnt;
    busy_next      = 1'b0;
    sdo_next       = 1'b0;
    sdo_valid_next = 1'b0;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          // MSB goes straight to sdo; the remainder (plus parity) waits in shreg.
`ifdef REG_RD_PARITY_EN
          shreg_next = (snap << 1) | DATA_W'(^snap);
`else
          shreg_next = snap << 1;
`endif
          cnt_next       = CNT_LOAD;
          busy_next      = 1'b1;
          sdo_next       = snap[DATA_W-1];
          sdo_valid_next = 1'b1;
        end
      end
      SHIFT: begin
        busy_next = 1'b1;
        if (cnt != '0) begin
          sdo_next       = shreg[DATA_W-1];
          sdo_valid_next = 1'b1;
          shreg_next     = shreg << 1;
          cnt_next       = cnt - 1'b1;
        end else begin
          done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_rd_ser.sv
// Self-checking bench for reg_rd_ser: cycle model compared every cycle plus literal stream checks.
module tb_reg_rd_ser;
  localparam int W  = 8;
  localparam int AW = 1;
`ifdef REG_RD_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [2*W-1:0] regs = '0;
  logic          busy, sdo, sdo_valid, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_rd_ser #(.DATA_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .regs(regs), .rd_req(rd_req), .rd_addr(rd_addr),
    .busy(busy), .sdo(sdo), .sdo_valid(sdo_valid), .done(done)
  );

  // Model: a transfer is (start edge, snapshot data); outputs follow from the edge offset.
  bit         m_active = 1'b0;
  int         m_start = 0;
  int         cyc = 0;
  logic [W-1:0] m_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if ((!m_active || (cyc + 1 - m_start) >= LEN + 2) && rd_req) begin
        m_active <= 1'b1;
        m_start  <= cyc + 1;
        m_data   <= regs[int'(rd_addr)*W +: W];
      end
    end
  end

  function automatic logic [3:0] expect_out();
    int j;
    logic b;
    j = cyc - m_start;
    if (!m_active || j > LEN) return 4'b0000;
    if (j == LEN) return 4'b1001;
    b = (j < W) ? m_data[W-1-j] : ^m_data;
    return {1'b1, b, 1'b1, 1'b0};
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    e = expect_out();
    checks++;
    if ({busy, sdo, sdo_valid, done} !== e) begin
      errors++;
      $display("FAIL outputs cyc=%0d busy/sdo/vld/done got %b expected %b",
               cyc, {busy, sdo, sdo_valid, done}, e);
    end
  end

  // Stream collector and done bookkeeping.
  logic [31:0] cap = '0;
  int ncap = 0, ndone = 0, last_done = 0, prev_done = 0;
  always @(negedge clk) begin
    if (sdo_valid) begin
      cap = {cap[30:0], sdo};
      ncap++;
    end
    if (done) begin
      ndone++;
      prev_done = last_done;
      last_done = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lit(input logic [7:0] d, input logic p);
`ifdef REG_RD_PARITY_EN
    return {23'd0, d, p};
`else
    return {24'd0, d};
`endif
  endfunction

  function automatic logic [31:0] stream();
    return cap & ((32'd1 << LEN) - 1);
  endfunction

  task automatic issue(input logic [AW-1:0] a);
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
    #1;
  endtask

  initial begin
    int n0, d0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {28'd0, busy, sdo, sdo_valid, done}, 32'd0);
    rst = 1'b0;

    // Basic read of register 0
    regs = {8'h3C, 8'hA5};
    n0 = ncap;
    issue(1'b0);
    wait_done("t1");
    chk("t1_nbits", ncap - n0, LEN);
    chk("t1_stream", stream(), lit(8'hA5, 1'b0));
    $display("t1 addr0 data a5 stream=%0h", stream());

    // Inputs change at N+2; snapshot must hold
    regs = {8'h3C, 8'h00};
    n0 = ncap;
    @(negedge clk);
    rd_addr = 1'b1;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req  = 1'b0;
    @(negedge clk);
    regs    = 16'hFFFF;
    rd_addr = 1'b0;
    wait_done("t2");
    chk("t2_nbits", ncap - n0, LEN);
    chk("t2_stream", stream(), lit(8'h3C, 1'b0));
    $display("t2 addr1 data 3c with late change stream=%0h", stream());

    // Request during transfer is ignored
    regs = {8'h3C, 8'hA5};
    d0 = ndone;
    issue(1'b0);
    repeat (2) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    wait_done("t3");
    chk("t3_stream", stream(), lit(8'hA5, 1'b0));
    repeat (LEN + 4) @(negedge clk);
    #1;
    chk("t3_done_count", ndone - d0, 1);
    chk("t3_busy_idle", {31'd0, busy}, 32'd0);
    $display("t3 ignored mid-transfer request done_count=%0d", ndone - d0);

    // Reset mid-transfer aborts without done
    d0 = ndone;
    issue(1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_busy_rst", {31'd0, busy}, 32'd0);
    chk("t4_sdo_rst", {31'd0, sdo}, 32'd0);
    chk("t4_valid_rst", {31'd0, sdo_valid}, 32'd0);
    chk("t4_done_rst", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n0 = ncap;
    rd_addr = 1'b0;
    rd_req  = 1'b1;
    @(negedge clk);
    rd_req  = 1'b0;
    wait_done("t4");
    chk("t4_nbits", ncap - n0, LEN);
    chk("t4_stream", stream(), lit(8'hA5, 1'b0));
    chk("t4_done_count", ndone - d0, 1);
    $display("t4 reset abort then new read stream=%0h", stream());

    // rd_req held high: back-to-back transfers
    regs = {8'hFF, 8'h01};
    rd_addr = 1'b0;
    n0 = ncap;
    @(negedge clk);
    rd_req = 1'b1;
    wait_done("t5a");
    chk("t5a_nbits", ncap - n0, LEN);
    chk("t5a_stream", stream(), lit(8'h01, 1'b1));
    n0 = ncap;
    wait_done("t5b");
    rd_req = 1'b0;
    chk("t5b_nbits", ncap - n0, LEN);
    chk("t5b_stream", stream(), lit(8'h01, 1'b1));
    chk("t5_spacing", last_done - prev_done, LEN + 2);
    $display("t5 back-to-back spacing=%0d", last_done - prev_done);

    // All-ones register
    n0 = ncap;
    issue(1'b1);
    wait_done("t6");
    chk("t6_stream", stream(), lit(8'hFF, 1'b0));
    $display("t6 addr1 data ff stream=%0h", stream());

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
